// File: rtl/ram_bus_bridge_if.sv
// ram_bus_bridge_if: CPU native bus plus word-RAM port bundle.
// slave = bridge view, master = CPU/RAM environment view.
interface ram_bus_bridge_if #(
  parameter int ADDR_BITS = 12
);
  logic                 mem_valid;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_ready;
  logic [31:0]          mem_rdata;
  logic                 ram_wen;
  logic [ADDR_BITS-1:0] ram_address;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    input  ram_rdata,
    output mem_ready,
    output mem_rdata,
    output ram_wen,
    output ram_address,
    output ram_wdata
  );

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    output ram_rdata,
    input  mem_ready,
    input  mem_rdata,
    input  ram_wen,
    input  ram_address,
    input  ram_wdata
  );
endinterface

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: PicoRV32 native bus to word RAM, RMW for partial stores.
// Optional RAM_BRIDGE_STATS_EN adds saturating rd_count/wr_count outputs.
module ram_bus_bridge #(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  ram_bus_bridge_if.slave bus
`ifdef RAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MERGE,
    WRITE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 sel;
  logic [31:0]          merged;
  logic                 unused_addr_lsb;

  // Byte placement comes from the strobes only.
  assign unused_addr_lsb = ^bus.mem_addr[1:0];

  assign sel = bus.mem_valid &&
    (bus.mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);

  // Overlay strobed CPU bytes onto the current RAM word.
  always_comb begin
    merged = bus.ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_wstrb[i]) begin
        merged[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // State, address and write-word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: accept in IDLE, merge partial stores, finish in one cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d = {bus.mem_addr[ADDR_BITS-1:2], 2'b00};
          if (bus.mem_wstrb == 4'b0000) begin
            state_d = READ;
          end else if (bus.mem_wstrb == 4'b1111) begin
            state_d = WRITE;
            wdata_d = bus.mem_wdata;
          end else begin
            state_d = MERGE;
          end
        end
      end
      READ: begin
        state_d = IDLE;
      end
      MERGE: begin
        if (bus.mem_valid) begin
          state_d = WRITE;
          wdata_d = merged;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_ready   = (state_q == READ) || (state_q == WRITE);
  assign bus.mem_rdata   = (state_q == READ) ? bus.ram_rdata : 32'h0;
  assign bus.ram_wen     = (state_q == WRITE);
  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wdata_q;

`ifdef RAM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Saturating completion counters; a merged store counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_q == READ && rd_cnt_q != 16'hFFFF) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (state_q == WRITE && wr_cnt_q != 16'hFFFF) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ram_bus_bridge.sv
// tb_ram_bus_bridge: random CPU traffic against a transaction-level model.
// Word RAM modelled here; expectations from a shadow memory.
module tb_ram_bus_bridge;
  localparam int AB = 12;
  localparam int NW = 1 << (AB - 2);

  logic clk = 1'b0;
  logic reset;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ram_bus_bridge_if #(.ADDR_BITS(AB)) bus ();

`ifdef RAM_BRIDGE_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  int          rd_m = 0;
  int          wr_m = 0;
  logic        pin_cnt_en = 1'b0;
  int          pin_rd = 0;
  int          pin_wr = 0;
`endif

  ram_bus_bridge #(
    .ADDR_BITS(AB),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef RAM_BRIDGE_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  logic [31:0] ram [NW];
  assign bus.ram_rdata = ram[bus.ram_address[AB-1:2]];
  always @(posedge clk) begin
    if (bus.ram_wen) ram[bus.ram_address[AB-1:2]] <= bus.ram_wdata;
  end

  logic [31:0] shadow [32];
  logic        exp_valid = 1'b0;
  int          exp_cyc = 0;
  logic        exp_read = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_wd = '0;
  logic [AB-1:0] exp_addr = '0;
  logic        pin_en = 1'b0;
  logic [31:0] pin_val = '0;
  wire         er = exp_valid && (cyc == exp_cyc);

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  st);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = st[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_ready", 32'(bus.mem_ready), 32'h0);
      chk("rst_rdata", bus.mem_rdata, 32'h0);
      chk("rst_wen", 32'(bus.ram_wen), 32'h0);
      chk("rst_addr", 32'(bus.ram_address), 32'h0);
      chk("rst_wdata", bus.ram_wdata, 32'h0);
`ifdef RAM_BRIDGE_STATS_EN
      rd_m = 0;
      wr_m = 0;
      chk("rst_rd_count", 32'(rd_count), 32'h0);
      chk("rst_wr_count", 32'(wr_count), 32'h0);
`endif
    end else begin
      chk("mem_ready", 32'(bus.mem_ready), 32'(er));
      chk("mem_rdata", bus.mem_rdata, (er && exp_read) ? exp_rd : 32'h0);
      chk("ram_wen", 32'(bus.ram_wen), 32'(er && !exp_read));
      if (er && !exp_read) begin
        chk("ram_address", 32'(bus.ram_address), 32'(exp_addr));
        chk("ram_wdata", bus.ram_wdata, exp_wd);
      end
      if (er && pin_en) begin
        chk("pinned", exp_read ? bus.mem_rdata : bus.ram_wdata, pin_val);
      end
`ifdef RAM_BRIDGE_STATS_EN
      chk("rd_count", 32'(rd_count), 32'(rd_m));
      chk("wr_count", 32'(wr_count), 32'(wr_m));
      if (pin_cnt_en) begin
        chk("pin_rd_count", 32'(rd_count), 32'(pin_rd));
        chk("pin_wr_count", 32'(wr_count), 32'(pin_wr));
      end
      if (er && exp_read && rd_m < 65535) rd_m = rd_m + 1;
      if (er && !exp_read && wr_m < 65535) wr_m = wr_m + 1;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    exp_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st);
    logic [4:0] w;
    w = addr[6:2];
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    bus.mem_wstrb = st;
    bus.mem_valid = 1'b1;
    if (addr[31:AB] != '0) begin
      exp_valid = 1'b0;
      repeat (10) step();
    end else begin
      exp_read  = (st == 4'h0);
      exp_rd    = shadow[w];
      exp_wd    = merge(shadow[w], wd, st);
      exp_addr  = {addr[AB-1:2], 2'b00};
      exp_cyc   = cyc + (((st == 4'h0) || (st == 4'hF)) ? 1 : 2);
      exp_valid = 1'b1;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (bus.mem_ready) break;
      end
      step();
      if (!exp_read) shadow[w] = exp_wd;
      exp_valid = 1'b0;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  task automatic pinned(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] v);
    pin_en  = 1'b1;
    pin_val = v;
    txn(addr, wd, st);
    pin_en  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 32; i++) txn(32'(i * 4), $urandom, 4'hF);

    pinned(32'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    pinned(32'h010, 32'h0, 4'h0, 32'hDEADBEEF);
    pinned(32'h012, 32'h00AA0000, 4'b0100, 32'hDEAABEEF);
    pinned(32'h010, 32'h0, 4'h0, 32'hDEAABEEF);

    txn(32'h0000_1000, 32'h12345678, 4'hF);
    step();
    txn(32'h010, 32'h0, 4'h0);

    bus.mem_addr  = 32'h020;
    bus.mem_wdata = 32'h000000FF;
    bus.mem_wstrb = 4'b0001;
    bus.mem_valid = 1'b1;
    step();
    reset = 1'b1;
    step();
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    step();
    reset = 1'b0;
    txn(32'h020, 32'h0, 4'h0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[31:AB] == '0) a[AB] = 1'b1;
      end else begin
        a = {25'h0, 5'($urandom), 2'($urandom)};
      end
      d = $urandom;
      case ($urandom_range(0, 3))
        0: s = 4'h0;
        1: s = 4'hF;
        default: s = 4'($urandom);
      endcase
      txn(a, d, s);
      repeat ($urandom_range(0, 2)) step();
    end

`ifdef RAM_BRIDGE_STATS_EN
    do_reset();
    txn(32'h004, 32'h0, 4'h0);
    txn(32'h008, 32'h0, 4'h0);
    txn(32'h00C, 32'h0, 4'h0);
    txn(32'h004, 32'h11223344, 4'hF);
    txn(32'h008, 32'h55000000, 4'b1000);
    pin_rd = 3;
    pin_wr = 2;
    pin_cnt_en = 1'b1;
    step();
    pin_cnt_en = 1'b0;
    do_reset();
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_bus_bridge.md
Name: ram_bus_bridge

Overview:
- Adapts the PicoRV32 native memory interface (valid/ready, byte strobes) to the on-chip word RAM port (wen, word address, 32-bit wdata, combinational rdata).
- The RAM has no byte enables, so partial-word stores are done as a read-modify-write inside the bridge.
- Sits between the CPU bus decode and the RAM instance.
- Responds only to addresses inside its window; outside the window it stays silent so other slaves can respond.

Parameters:
- ADDR_BITS, 12: RAM byte-address width; RAM word index is address[ADDR_BITS-1:2].
- BASE_ADDR, 32'h0000_0000: window base; must be aligned to 2**ADDR_BITS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; 0 whenever mem_ready=0.
- ram_wen  out  1  RAM write enable, one-cycle pulse.
- ram_address  out  ADDR_BITS  RAM byte address; bits [1:0] always 0.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM combinational read data for ram_address.

Behaviour:
- sel = mem_valid && (mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]).
- States: IDLE, READ, MERGE, WRITE.
- On reset: state=IDLE; mem_ready=0; mem_rdata=0; ram_wen=0; ram_address=0; ram_wdata=0; merge register=0.
- IDLE:
  - If sel: latch ram_address = {mem_addr[ADDR_BITS-1:2], 2'b00}.
  - wstrb==0 -> READ.
  - wstrb==4'b1111 -> WRITE, with ram_wdata = mem_wdata.
  - Any other wstrb -> MERGE.
  - If !sel: stay IDLE.
- READ:
  - mem_ready=1, mem_rdata=ram_rdata (combinational from RAM, stable this cycle) -> IDLE.
  - Read latency: mem_ready in the cycle after mem_valid is first seen.
- MERGE:
  - For each byte i: ram_wdata[8i+7:8i] = wstrb[i] ? mem_wdata byte i : ram_rdata byte i. Registered -> WRITE.
  - If mem_valid is low here (protocol violation): -> IDLE, no write, no ready.
- WRITE:
  - ram_wen=1 and mem_ready=1 in the same cycle; mem_rdata=0 -> IDLE.
  - Full-word write latency 1; partial write latency 2.
- Back-to-back: after READ/WRITE the bridge spends one cycle in IDLE. It never re-accepts on the ready cycle. The CPU drops valid on the edge where it samples ready.
- ram_wen is never asserted outside WRITE. Reads never cause a write.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. An in-flight MERGE is discarded; the RAM is untouched.
- Address wrap: only the low ADDR_BITS bits reach the RAM. Window decode guarantees no aliasing.
- mem_addr[1:0] is ignored; byte placement comes from wstrb only.

Optional Feature:
- Macro: RAM_BRIDGE_STATS_EN.
- Defined: adds output ports rd_count (16) and wr_count (16).
  - Each increments on a READ or WRITE completion respectively.
  - Both saturate at 16'hFFFF and clear on reset.
  - A partial write counts once.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then full write: addr 0x010, wdata 0xDEADBEEF, wstrb 1111.
  -> ram_wen pulses with ram_address 0x010 and ram_wdata 0xDEADBEEF in cycle+1; mem_ready=1 in the same cycle.
- Read: addr 0x010, wstrb 0000.
  -> mem_ready in cycle+1 with mem_rdata 0xDEADBEEF; mem_rdata=0 in all other cycles.
- Partial write: addr 0x012, wdata 0x00AA0000, wstrb 0100.
  -> no wen in cycle+1; wen in cycle+2 with ram_wdata 0xDEAABEEF. A following read returns 0xDEAABEEF.
- Out-of-window request with BASE_ADDR=0: addr 0x0000_1000.
  -> mem_ready and ram_wen stay 0 for 10 cycles; state remains IDLE.
- Reset asserted during MERGE of wstrb 0001 to 0x020.
  -> no ram_wen, mem_ready=0. The word at 0x020 is unchanged on a later read.
- With RAM_BRIDGE_STATS_EN: 3 reads and 2 writes (one partial) -> rd_count=3, wr_count=2. After reset -> both 0.
